// File: rtl/dm_access_unit.sv
// Load/store access unit in front of a word-wide data memory: sub-word loads are
// extended, sub-word stores go through read-modify-write, bad requests are rejected.
module dm_access_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS);

  logic [2:0]  state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Reject reserved sizes, misaligned half/word accesses and words beyond DM depth.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])
      req_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DM_LIMIT)
      req_err = 1'b1;
  end

  always_comb begin
    byte_sel = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dm_rdata;
    endcase
  end

  // Word stores bypass the merge register; sub-word stores patch one lane of it.
  always_comb begin
    merged = merge_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: begin
        if (addr_q[1])
          merged[31:16] = wdata_q[15:0];
        else
          merged[15:0] = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            if (req_err) begin
              rdata_q <= 32'h0;
              state   <= RESP;
            end else if (!req_we)
              state <= RD;
            else if (req_size == SZ_WORD)
              state <= WR;
            else
              state <= RMW_RD;
          end
        end
        RD: begin
          rdata_q <= load_ext;
          state   <= RESP;
        end
        RMW_RD: begin
          merge_q <= dm_rdata;
          state   <= WR;
        end
        WR: begin
          rdata_q <= 32'h0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;
  assign dm_we     = (state == WR);
  assign dm_addr   = (state == RD || state == RMW_RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dm_wdata  = dm_we ? merged : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: a behavioural DM, directed requests, and a scoreboard
// monitor that checks every response pulse against queued expectations.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  dm_access_unit #(.DM_WORDS(1024)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural DM: combinational read, commit on the falling edge.
  logic [31:0] mem [0:1023];
  assign dm_rdata = (dm_addr[31:12] == 20'h0) ? mem[dm_addr[11:2]] : 32'h0;
  always @(negedge clk)
    if (dm_we && dm_addr[31:12] == 20'h0) mem[dm_addr[11:2]] <= dm_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int we_cycles = 0;
  int rsp_count = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dm_we) we_cycles++;
    if (rsp_valid) begin
      rsp_count++;
      if (sbq.size() == 0)
        check("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int lat, input bit push);
    int c = 0;
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      if (req_ready) begin
        c   = cyc;
        got = 1;
      end
      @(posedge clk);
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    else if (push) sbq.push_back('{exp_err, exp_rdata, c + lat});
  endtask

  task automatic wait_done();
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("rsp_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    do_req(1'b1, size, 1'b0, addr, wdata, 1'b0, 32'h0, lat, 1'b1);
    wait_done();
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] exp);
    do_req(1'b0, size, uns, addr, 32'h0, 1'b0, exp, 2, 1'b1);
    wait_done();
  endtask

  task automatic bad(input logic we, input logic [1:0] size, input logic [31:0] addr);
    do_req(we, size, 1'b0, addr, 32'hDEADBEEF, 1'b1, 32'h0, 1, 1'b1);
    wait_done();
  endtask

  initial begin
    int w0;
    int r0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    #1 rstn = 1'b0;
    #2;
    check("reset_req_ready", {31'h0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'h0, rsp_err}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_dm_we", {31'h0, dm_we}, 32'd0);
    check("reset_dm_addr", dm_addr, 32'h0);
    check("reset_dm_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Word store then word load.
    w0 = we_cycles;
    st(2'b10, 32'h10, 32'h11223344, 2);
    check("sw_we_cycles", 32'(we_cycles - w0), 32'd1);
    check("sw_mem", mem[4], 32'h11223344);
    w0 = we_cycles;
    ld(2'b10, 1'b0, 32'h10, 32'h11223344);
    check("lw_we_cycles", 32'(we_cycles - w0), 32'd0);

    // Sub-word read-modify-write stores; upper wdata bits must be ignored.
    st(2'b00, 32'h13, 32'h123456AA, 3);
    ld(2'b10, 1'b0, 32'h10, 32'hAA223344);
    st(2'b01, 32'h10, 32'hFFFFBEEF, 3);
    ld(2'b10, 1'b0, 32'h10, 32'hAA22BEEF);

    // Lane selection and extension.
    st(2'b10, 32'h40, 32'h80FF7F01, 2);
    ld(2'b00, 1'b0, 32'h40, 32'h00000001);
    ld(2'b00, 1'b0, 32'h41, 32'h0000007F);
    ld(2'b00, 1'b0, 32'h42, 32'hFFFFFFFF);
    ld(2'b00, 1'b1, 32'h43, 32'h00000080);
    ld(2'b01, 1'b0, 32'h40, 32'h00007F01);
    ld(2'b01, 1'b0, 32'h42, 32'hFFFF80FF);
    ld(2'b01, 1'b1, 32'h42, 32'h000080FF);

    // Rejected requests, then the highest legal word.
    st(2'b10, 32'hFFC, 32'hCAFEF00D, 2);
    w0 = we_cycles;
    bad(1'b0, 2'b01, 32'h11);
    bad(1'b1, 2'b10, 32'h12);
    bad(1'b0, 2'b11, 32'h10);
    bad(1'b0, 2'b10, 32'h1000);
    bad(1'b1, 2'b00, 32'h1000);
    check("err_we_cycles", 32'(we_cycles - w0), 32'd0);
    check("err_mem_unchanged", mem[4], 32'hAA22BEEF);
    check("err_top_unchanged", mem[1023], 32'hCAFEF00D);
    ld(2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D);

    // Reset while the read half of a byte store is in flight.
    st(2'b10, 32'h20, 32'h55667788, 2);
    r0 = rsp_count;
    w0 = we_cycles;
    do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h000000EE, 1'b0, 32'h0, 3, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_dm_we", {31'h0, dm_we}, 32'd0);
    check("rst_mid_req_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_count - r0), 32'd0);
    check("rst_mid_no_we", 32'(we_cycles - w0), 32'd0);
    check("rst_mid_mem", mem[8], 32'h55667788);
    check("rst_mid_ready_after", {31'h0, req_ready}, 32'd1);

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hAA22BEEF, 2, 1'b1);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000AA, 2, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b0, 32'hFFFF80FF, 2, 1'b1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
